// File: rtl/boss_aggro_tracker.sv
// Threat accumulators with frame-based decay feeding the boss jump-target aggro values,
// plus a hold-time hysteresis filter that decides which player the boss faces.
module boss_aggro_tracker #(
  parameter int unsigned ACC_W       = 8,
  parameter int unsigned HIT_SHIFT   = 2,
  parameter int unsigned ACC_SHIFT   = 4,
  parameter int unsigned DECAY_TICKS = 30,
  parameter int unsigned DECAY_STEP  = 1,
  parameter int unsigned HOLD_TICKS  = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [1:0] game_active,
  input  logic       p1_hit,
  input  logic [3:0] p1_dmg,
  input  logic [3:0] p1_base,
  input  logic       p2_hit,
  input  logic [3:0] p2_dmg,
  input  logic [3:0] p2_base,
  output logic [3:0] class_aggro,
  output logic [3:0] player_2_aggro,
  output logic       target_p2
);

  localparam int unsigned DECAY_W = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
  localparam int unsigned HOLD_W  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [DECAY_W-1:0] DECAY_LAST = DECAY_W'(DECAY_TICKS - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [ACC_W:0]     ACC_MAX    = {1'b0, {ACC_W{1'b1}}};
  localparam logic [ACC_W:0]     DEC_AMT    = (ACC_W+1)'(DECAY_STEP);

  typedef enum logic {
    TRACK_P1 = 1'b0,
    TRACK_P2 = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc1_q, acc1_d;
  logic [ACC_W-1:0]   acc2_q, acc2_d;
  logic [DECAY_W-1:0] decay_cnt_q, decay_cnt_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [3:0]         class_aggro_q, class_aggro_d;
  logic [3:0]         p2_aggro_q, p2_aggro_d;

  logic in_menu;
  logic running;
  logic decay_now;
  logic raw_p2;
  logic agree;

  // Saturate at the top first, then floor at zero, so a hit and a decay in
  // the same cycle both land even when the accumulator is pinned at full.
  function automatic logic [ACC_W-1:0] acc_step(input logic [ACC_W-1:0] acc,
                                                input logic             hit,
                                                input logic [3:0]       dmg,
                                                input logic             dec);
    logic [ACC_W:0] add;
    logic [ACC_W:0] sum;
    logic [ACC_W:0] sat;
    logic [ACC_W:0] sub;
    add = hit ? ((ACC_W+1)'(dmg) << HIT_SHIFT) : '0;
    sum = {1'b0, acc} + add;
    sat = (sum > ACC_MAX) ? ACC_MAX : sum;
    sub = dec ? DEC_AMT : '0;
    return (sat >= sub) ? ACC_W'(sat - sub) : '0;
  endfunction

  function automatic logic [3:0] aggro_of(input logic [3:0]       base,
                                          input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] contrib;
    logic [3:0]       contrib4;
    logic [4:0]       sum;
    contrib  = acc >> ACC_SHIFT;
    contrib4 = (contrib > ACC_W'(15)) ? 4'hF : contrib[3:0];
    sum      = {1'b0, base} + {1'b0, contrib4};
    return (sum > 5'd15) ? 4'hF : sum[3:0];
  endfunction

  assign in_menu   = (game_active == 2'd0);
  assign running   = (game_active == 2'd1);
  assign decay_now = frame_tick && (decay_cnt_q == DECAY_LAST);
  // Strict compare: a tie keeps the local player, same as the boss stage.
  assign raw_p2    = (p2_aggro_q > class_aggro_q);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    acc1_d      = acc1_q;
    acc2_d      = acc2_q;
    decay_cnt_d = decay_cnt_q;
    if (in_menu) begin
      acc1_d      = '0;
      acc2_d      = '0;
      decay_cnt_d = '0;
    end else if (running) begin
      acc1_d = acc_step(acc1_q, p1_hit, p1_dmg, decay_now);
      acc2_d = acc_step(acc2_q, p2_hit, p2_dmg, decay_now);
      if (frame_tick) begin
        decay_cnt_d = (decay_cnt_q == DECAY_LAST) ? '0 : decay_cnt_q + 1'b1;
      end
    end
  end

  // Aggro tracks the registered accumulators in every mode, one clock behind.
  always_comb begin
    class_aggro_d = aggro_of(p1_base, acc1_q);
    p2_aggro_d    = aggro_of(p2_base, acc2_q);
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    agree      = (state_q == TRACK_P1) ? raw_p2 : !raw_p2;
    if (in_menu) begin
      state_d    = TRACK_P1;
      hold_cnt_d = '0;
    end else if (running && frame_tick) begin
      if (!agree) begin
        hold_cnt_d = '0;
      end else if (hold_cnt_q == HOLD_LAST) begin
        hold_cnt_d = '0;
        state_d    = (state_q == TRACK_P1) ? TRACK_P2 : TRACK_P1;
      end else begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= TRACK_P1;
      acc1_q        <= '0;
      acc2_q        <= '0;
      decay_cnt_q   <= '0;
      hold_cnt_q    <= '0;
      class_aggro_q <= '0;
      p2_aggro_q    <= '0;
    end else begin
      state_q       <= state_d;
      acc1_q        <= acc1_d;
      acc2_q        <= acc2_d;
      decay_cnt_q   <= decay_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      class_aggro_q <= class_aggro_d;
      p2_aggro_q    <= p2_aggro_d;
    end
  end

  assign class_aggro    = class_aggro_q;
  assign player_2_aggro = p2_aggro_q;
  assign target_p2      = (state_q == TRACK_P2);

endmodule

// File: tb/tb_boss_aggro_tracker.sv
// Directed bench for boss_aggro_tracker: latency, saturation, decay, hysteresis and mode gating.
module tb_boss_aggro_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic [1:0] game_active;
  logic       p1_hit;
  logic [3:0] p1_dmg;
  logic [3:0] p1_base;
  logic       p2_hit;
  logic [3:0] p2_dmg;
  logic [3:0] p2_base;
  logic [3:0] class_aggro;
  logic [3:0] player_2_aggro;
  logic       target_p2;

  int n_checks = 0;
  int n_errors = 0;

  boss_aggro_tracker dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_tick     (frame_tick),
    .game_active    (game_active),
    .p1_hit         (p1_hit),
    .p1_dmg         (p1_dmg),
    .p1_base        (p1_base),
    .p2_hit         (p2_hit),
    .p2_dmg         (p2_dmg),
    .p2_base        (p2_base),
    .class_aggro    (class_aggro),
    .player_2_aggro (player_2_aggro),
    .target_p2      (target_p2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; game_active = 2'd0;
    p1_hit = 1'b0; p1_dmg = 4'd0; p1_base = 4'd3;
    p2_hit = 1'b0; p2_dmg = 4'd0; p2_base = 4'd2;
    step(); step();
    check("rst_class", 32'(class_aggro), 32'd0);
    check("rst_p2", 32'(player_2_aggro), 32'd0);
    check("rst_target", 32'(target_p2), 32'd0);

    rst_n = 1'b1; game_active = 2'd1;
    step();
    check("lat_class", 32'(class_aggro), 32'd3);
    check("lat_p2", 32'(player_2_aggro), 32'd2);
    check("lat_target", 32'(target_p2), 32'd0);

    // Single hit: accumulator at edge N, aggro at N+1.
    p1_hit = 1'b1; p1_dmg = 4'd5;
    step();
    p1_hit = 1'b0;
    check("hit_acc1", 32'(dut.acc1_q), 32'd20);
    check("hit_class_n", 32'(class_aggro), 32'd3);
    step();
    check("hit_class_n1", 32'(class_aggro), 32'd4);

    // Decay on 30th frame combined with a hit: 20 + 4 - 1.
    frames(29);
    check("dec29_acc1", 32'(dut.acc1_q), 32'd20);
    frame_tick = 1'b1; p1_hit = 1'b1; p1_dmg = 4'd1;
    step();
    frame_tick = 1'b0; p1_hit = 1'b0;
    check("dec30_acc1", 32'(dut.acc1_q), 32'd23);
    check("dec30_acc2_floor", 32'(dut.acc2_q), 32'd0);
    step();
    check("dec_class", 32'(class_aggro), 32'd4);

    // Hysteresis: acc2 = 60 + 12 = 72 -> aggro 2 + 4 = 6 vs 4.
    p2_hit = 1'b1; p2_dmg = 4'd15;
    step();
    p2_dmg = 4'd3;
    step();
    p2_hit = 1'b0;
    step();
    check("hys_p2_aggro", 32'(player_2_aggro), 32'd6);
    frames(29);
    check("hys29_target", 32'(target_p2), 32'd0);
    check("hys29_hold", 32'(dut.hold_cnt_q), 32'd29);
    // Tie on frame 30: acc1 = 23 + 28 = 51 -> 3 + 3 = 6.
    p1_hit = 1'b1; p1_dmg = 4'd7;
    step();
    p1_hit = 1'b0;
    step();
    check("tie_class", 32'(class_aggro), 32'd6);
    frames(1);
    check("tie_hold", 32'(dut.hold_cnt_q), 32'd0);
    check("tie_target", 32'(target_p2), 32'd0);
    check("tie_acc1", 32'(dut.acc1_q), 32'd50);
    // acc2 = 71 + 16 = 87 -> 2 + 5 = 7.
    p2_hit = 1'b1; p2_dmg = 4'd4;
    step();
    p2_hit = 1'b0;
    step();
    check("hys2_p2_aggro", 32'(player_2_aggro), 32'd7);
    frames(30);
    check("hys2_30_target", 32'(target_p2), 32'd0);
    frames(29);
    check("hys2_59_target", 32'(target_p2), 32'd0);
    frames(1);
    check("hys2_60_target", 32'(target_p2), 32'd1);
    check("hys2_acc2", 32'(dut.acc2_q), 32'd85);

    // Saturation: 20 hits of 60 on top of 48.
    p1_hit = 1'b1; p1_dmg = 4'd15;
    for (int i = 0; i < 20; i++) step();
    p1_hit = 1'b0;
    check("sat_acc1", 32'(dut.acc1_q), 32'd255);
    step();
    check("sat_class", 32'(class_aggro), 32'd15);

    // Paused: hits and frames ignored.
    game_active = 2'd2;
    p1_hit = 1'b1; p2_hit = 1'b1; p1_dmg = 4'd15; p2_dmg = 4'd15; frame_tick = 1'b1;
    for (int i = 0; i < 5; i++) step();
    p1_hit = 1'b0; p2_hit = 1'b0; frame_tick = 1'b0;
    step();
    check("pause_acc1", 32'(dut.acc1_q), 32'd255);
    check("pause_acc2", 32'(dut.acc2_q), 32'd85);
    check("pause_class", 32'(class_aggro), 32'd15);
    check("pause_p2", 32'(player_2_aggro), 32'd7);
    check("pause_target", 32'(target_p2), 32'd1);
    check("pause_hold", 32'(dut.hold_cnt_q), 32'd0);

    // Menu: clears accumulators and target, outputs fall back to base.
    game_active = 2'd0; p1_hit = 1'b1; p1_dmg = 4'd9;
    step();
    p1_hit = 1'b0;
    check("menu_acc1", 32'(dut.acc1_q), 32'd0);
    check("menu_acc2", 32'(dut.acc2_q), 32'd0);
    check("menu_target", 32'(target_p2), 32'd0);
    step();
    check("menu_class", 32'(class_aggro), 32'd3);
    check("menu_p2", 32'(player_2_aggro), 32'd2);

    // Decay at zero stays at zero.
    game_active = 2'd1;
    frames(30);
    check("zero_acc1", 32'(dut.acc1_q), 32'd0);
    check("zero_acc2", 32'(dut.acc2_q), 32'd0);
    check("zero_class", 32'(class_aggro), 32'd3);

    // Reset mid-hold: acc2 = 120 -> 2 + 7 = 9.
    p2_hit = 1'b1; p2_dmg = 4'd15;
    step(); step();
    p2_hit = 1'b0;
    step();
    check("mid_p2_aggro", 32'(player_2_aggro), 32'd9);
    frames(10);
    check("mid_hold", 32'(dut.hold_cnt_q), 32'd10);
    check("mid_target", 32'(target_p2), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_class", 32'(class_aggro), 32'd0);
    check("arst_p2", 32'(player_2_aggro), 32'd0);
    check("arst_target", 32'(target_p2), 32'd0);
    check("arst_hold", 32'(dut.hold_cnt_q), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
